// File: rtl/inv_result_collector_pkg.sv
// Shared types and constants for the matrix-inverse result collector.
package inv_result_collector_pkg;

    localparam int SIZE  = 16;
    localparam int INT   = 4;
    localparam int FRAC  = 12;
    localparam int N     = 3;
    localparam int ELEMS = N * N;
    localparam int IDX_W = 4;

    typedef logic signed [SIZE-1:0] fx_t;
    typedef logic [IDX_W-1:0]       idx_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        CAPTURE,
        DRAIN
    } coll_state_t;

    localparam fx_t  FX_MAX   = {1'b0, {SIZE-1{1'b1}}};
    localparam fx_t  FX_MIN   = {1'b1, {SIZE-1{1'b0}}};
    localparam fx_t  FX_ONE   = fx_t'(1 << FRAC);
    localparam idx_t LAST_IDX = idx_t'(ELEMS - 1);

    // A word pinned at either rail means matrix_inv saturated its result.
    function automatic logic is_sat(input fx_t w);
        return (w == FX_MAX) || (w == FX_MIN);
    endfunction

endpackage

// File: rtl/inv_result_collector_if.sv
// Element stream from the collector to its consumer (valid/ready).
interface inv_result_collector_if
    import inv_result_collector_pkg::*;
();
    logic valid;
    logic ready;
    fx_t  data;
    idx_t index;
    logic last;

    modport master (output valid, output data, output index, output last, input ready);
    modport slave  (input valid, input data, input index, input last, output ready);
endinterface

// File: rtl/inv_result_buf.sv
// ELEMS-deep element store: one write port, two asynchronous read ports.
// Out-of-range read addresses return zero.
module inv_result_buf
    import inv_result_collector_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic we,
    input  idx_t waddr,
    input  fx_t  wdata,
    input  idx_t raddr_a,
    output fx_t  rdata_a,
    input  idx_t raddr_b,
    output fx_t  rdata_b
);

    fx_t mem [ELEMS];

    // Storage: cleared on reset, one element written per enabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ELEMS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr < idx_t'(ELEMS))) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a < idx_t'(ELEMS)) ? mem[raddr_a] : '0;
    assign rdata_b = (raddr_b < idx_t'(ELEMS)) ? mem[raddr_b] : '0;

endmodule

// File: rtl/inv_result_collector.sv
// Collects the 9-element serial result of matrix_inv into a local buffer,
// then replays it on a valid/ready stream and a random-access read port.
//
// state   | meaning
// IDLE    | waiting for inv_done; clr accepted here only
// REQ     | inv_read raised, matrix_inv starts streaming next cycle
// CAPTURE | one word stored per cycle; length/finish checked on word 8
// DRAIN   | buffer replayed on the stream, index 0..8
module inv_result_collector
    import inv_result_collector_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          inv_done,
    input  logic                          inv_finish,
    input  fx_t                           inv_data,
    output logic                          inv_read,
    inv_result_collector_if.master        m,
    input  idx_t                          rd_addr,
    output fx_t                           rd_data,
    output logic                          busy,
    output logic                          sat,
    output logic                          err,
    input  logic                          clr
);

    coll_state_t state;
    idx_t        cnt;
    idx_t        drain_addr;
    fx_t         drain_rdata;

    inv_result_buf u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (state == CAPTURE),
        .waddr   (cnt),
        .wdata   (inv_data),
        .raddr_a (drain_addr),
        .rdata_a (drain_rdata),
        .raddr_b (rd_addr),
        .rdata_b (rd_data)
    );

    // Look one element ahead so m.data is registered together with m.index.
    always_comb begin
        drain_addr = '0;
        if (state == DRAIN) begin
            drain_addr = m.index + idx_t'(1);
        end
    end

    assign busy = (state != IDLE);

    // Sequencer: request, capture, drain, with sticky status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            inv_read <= 1'b0;
            m.valid  <= 1'b0;
            m.data   <= '0;
            m.index  <= '0;
            m.last   <= 1'b0;
            sat      <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr) begin
                        sat <= 1'b0;
                        err <= 1'b0;
                    end else if (inv_done) begin
                        state    <= REQ;
                        inv_read <= 1'b1;
                    end
                end
                REQ: begin
                    state <= CAPTURE;
                    cnt   <= '0;
                end
                CAPTURE: begin
                    if (is_sat(inv_data)) begin
                        sat <= 1'b1;
                    end
                    if (cnt == LAST_IDX) begin
                        inv_read <= 1'b0;
                        cnt      <= '0;
                        if (inv_finish) begin
                            // Element 0 was written long ago, so it is readable now.
                            state   <= DRAIN;
                            m.valid <= 1'b1;
                            m.data  <= drain_rdata;
                            m.index <= '0;
                            m.last  <= 1'b0;
                        end else begin
                            state <= IDLE;
                            err   <= 1'b1;
                        end
                    end else if (inv_finish) begin
                        state    <= IDLE;
                        inv_read <= 1'b0;
                        cnt      <= '0;
                        err      <= 1'b1;
                    end else begin
                        cnt <= cnt + idx_t'(1);
                    end
                end
                DRAIN: begin
                    if (m.valid && m.ready) begin
                        if (m.index == LAST_IDX) begin
                            state   <= IDLE;
                            m.valid <= 1'b0;
                            m.data  <= '0;
                            m.index <= '0;
                            m.last  <= 1'b0;
                        end else begin
                            m.index <= m.index + idx_t'(1);
                            m.data  <= drain_rdata;
                            m.last  <= ((m.index + idx_t'(1)) == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_result_collector.sv
// Scenario bench for inv_result_collector with a data scoreboard.
module tb_inv_result_collector;
    import inv_result_collector_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inv_done = 1'b0;
    logic        inv_finish = 1'b0;
    logic [15:0] inv_data = '0;
    logic        inv_read;
    logic [3:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic        busy;
    logic        sat;
    logic        err;
    logic        clr = 1'b0;

    inv_result_collector_if m_if ();

    inv_result_collector dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inv_done   (inv_done),
        .inv_finish (inv_finish),
        .inv_data   (inv_data),
        .inv_read   (inv_read),
        .m          (m_if),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .sat        (sat),
        .err        (err),
        .clr        (clr)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] stim [9];
    logic [15:0] sb [$];

    // Acts as matrix_inv: pulse done, then stream nwords once read is up.
    task automatic feed(input int nwords, input int finish_at, input bit push,
                        output bit saw_valid);
        saw_valid = 1'b0;
        @(negedge clk);
        inv_done = 1'b1;
        @(negedge clk);
        inv_done = 1'b0;
        n_tests++;
        if (inv_read !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL read_req: inv_read=%b busy=%b required 1 1", inv_read, busy);
        end
        @(negedge clk);
        for (int k = 0; k < nwords; k++) begin
            inv_data   = stim[k];
            inv_finish = (k == finish_at);
            if (push) sb.push_back(stim[k]);
            if (m_if.valid) saw_valid = 1'b1;
            @(negedge clk);
        end
        inv_finish = 1'b0;
        inv_data   = '0;
    endtask

    // Consumer: mode 0 ready always high, mode 1 ready pattern 1,0,0,1,0,0...
    task automatic drain(input int mode, input int max_beats, output int cycles);
        int          beats = 0;
        int          exp_idx = 0;
        bit          stalled = 1'b0;
        logic [15:0] held_data = '0;
        logic [3:0]  held_idx = '0;
        logic [15:0] exp;
        cycles = 0;
        while (beats < max_beats && cycles < 60) begin
            m_if.ready = (mode == 0) ? 1'b1 : ((cycles % 3) == 0);
            if (m_if.valid) begin
                if (stalled) begin
                    n_tests++;
                    if (m_if.data !== held_data || m_if.index !== held_idx) begin
                        n_fail++;
                        $display("FAIL stall_hold: data=%h idx=%0d required %h %0d",
                                 m_if.data, m_if.index, held_data, held_idx);
                    end
                end
                if (m_if.ready) begin
                    stalled = 1'b0;
                    n_tests++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL beat_extra: data=%h with empty scoreboard", m_if.data);
                    end else begin
                        exp = sb.pop_front();
                        if (m_if.data !== exp || m_if.index !== 4'(exp_idx) ||
                            m_if.last !== (exp_idx == 8)) begin
                            n_fail++;
                            $display("FAIL beat: data=%h idx=%0d last=%b required %h %0d %b",
                                     m_if.data, m_if.index, m_if.last, exp, exp_idx, exp_idx == 8);
                        end
                    end
                    exp_idx++;
                    beats++;
                end else begin
                    stalled   = 1'b1;
                    held_data = m_if.data;
                    held_idx  = m_if.index;
                end
            end
            cycles++;
            @(negedge clk);
        end
        m_if.ready = 1'b0;
        n_tests++;
        if (beats != max_beats) begin
            n_fail++;
            $display("FAIL beat_count: got %0d beats required %0d", beats, max_beats);
        end
    endtask

    task automatic check_idle_clean(input string name, input logic exp_err, input logic exp_sat);
        n_tests++;
        if (m_if.valid !== 1'b0 || busy !== 1'b0 || err !== exp_err || sat !== exp_sat) begin
            n_fail++;
            $display("FAIL %s: valid=%b busy=%b err=%b sat=%b required 0 0 %b %b",
                     name, m_if.valid, busy, err, sat, exp_err, exp_sat);
        end
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++;
        if (inv_read !== 1'b0 || m_if.valid !== 1'b0 || m_if.data !== 16'h0 ||
            m_if.index !== 4'h0 || m_if.last !== 1'b0 || busy !== 1'b0 ||
            sat !== 1'b0 || err !== 1'b0 || rd_data !== 16'h0) begin
            n_fail++;
            $display("FAIL reset: read=%b valid=%b data=%h idx=%0d last=%b busy=%b sat=%b err=%b rd=%h required all 0",
                     inv_read, m_if.valid, m_if.data, m_if.index, m_if.last, busy, sat, err, rd_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_identity();
        bit sv;
        int cyc;
        stim = '{16'h1000, 16'h0, 16'h0, 16'h0, 16'h1000, 16'h0, 16'h0, 16'h0, 16'h1000};
        feed(9, 8, 1'b1, sv);
        n_tests++;
        if (m_if.valid !== 1'b1 || inv_read !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_start: valid=%b inv_read=%b required 1 0", m_if.valid, inv_read);
        end
        drain(0, 9, cyc);
        n_tests++;
        if (cyc != 9) begin
            n_fail++;
            $display("FAIL best_case: %0d cycles required 9", cyc);
        end
        check_idle_clean("identity_end", 1'b0, 1'b0);
    endtask

    task automatic test_back_pressure();
        bit sv;
        int cyc;
        for (int k = 0; k < 9; k++) stim[k] = 16'(k + 1);
        feed(9, 8, 1'b1, sv);
        drain(1, 9, cyc);
        check_idle_clean("backpressure_end", 1'b0, 1'b0);
    endtask

    task automatic test_early_finish();
        bit sv;
        for (int k = 0; k < 9; k++) stim[k] = 16'(16'h0100 + k);
        feed(6, 5, 1'b0, sv);
        repeat (3) begin
            if (m_if.valid) sv = 1'b1;
            @(negedge clk);
        end
        n_tests++;
        if (sv !== 1'b0) begin
            n_fail++;
            $display("FAIL early_valid: m_valid rose, required never");
        end
        check_idle_clean("early_finish", 1'b1, 1'b0);
        n_tests++;
        if (rd_data !== stim[0]) begin
            n_fail++;
            $display("FAIL early_partial: rd_data=%h required %h", rd_data, stim[0]);
        end
        // clr wins over a done in the same cycle.
        clr = 1'b1;
        inv_done = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        inv_done = 1'b0;
        check_idle_clean("clr_priority", 1'b0, 1'b0);
    endtask

    task automatic test_missing_finish();
        bit sv;
        for (int k = 0; k < 9; k++) stim[k] = 16'(16'hA000 + 16'h0111 * k);
        feed(9, -1, 1'b0, sv);
        @(negedge clk);
        check_idle_clean("missing_finish", 1'b1, 1'b0);
        rd_addr = 4'd8;
        #1;
        n_tests++;
        if (rd_data !== stim[8]) begin
            n_fail++;
            $display("FAIL rd_addr8: rd_data=%h required %h", rd_data, stim[8]);
        end
        rd_addr = 4'd3;
        #1;
        n_tests++;
        if (rd_data !== stim[3]) begin
            n_fail++;
            $display("FAIL rd_addr3: rd_data=%h required %h", rd_data, stim[3]);
        end
        rd_addr = 4'd9;
        #1;
        n_tests++;
        if (rd_data !== 16'h0) begin
            n_fail++;
            $display("FAIL rd_addr9: rd_data=%h required 0000", rd_data);
        end
        rd_addr = 4'd0;
        do_clr();
        check_idle_clean("missing_clr", 1'b0, 1'b0);
    endtask

    task automatic test_sat();
        bit sv;
        int cyc;
        for (int k = 0; k < 9; k++) stim[k] = 16'(16'h0200 + k);
        stim[2] = 16'h7FFF;
        stim[5] = 16'h8000;
        feed(9, 8, 1'b1, sv);
        drain(0, 9, cyc);
        check_idle_clean("sat_set", 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check_idle_clean("sat_sticky", 1'b0, 1'b1);
        do_clr();
        check_idle_clean("sat_clr", 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_drain();
        bit sv;
        int cyc;
        for (int k = 0; k < 9; k++) stim[k] = 16'(16'h0300 + k);
        feed(9, 8, 1'b1, sv);
        drain(0, 4, cyc);
        n_tests++;
        if (m_if.valid !== 1'b1 || m_if.index !== 4'd4 || m_if.data !== stim[4]) begin
            n_fail++;
            $display("FAIL pre_reset: valid=%b idx=%0d data=%h required 1 4 %h",
                     m_if.valid, m_if.index, m_if.data, stim[4]);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (m_if.valid !== 1'b0 || m_if.data !== 16'h0 || m_if.index !== 4'h0 ||
            m_if.last !== 1'b0 || inv_read !== 1'b0 || busy !== 1'b0 || rd_data !== 16'h0) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b data=%h idx=%0d last=%b read=%b busy=%b rd=%h required all 0",
                     m_if.valid, m_if.data, m_if.index, m_if.last, inv_read, busy, rd_data);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 9; k++) stim[k] = 16'(16'h0400 + k);
        feed(9, 8, 1'b1, sv);
        drain(0, 9, cyc);
        check_idle_clean("post_reset_run", 1'b0, 1'b0);
    endtask

    initial begin
        m_if.ready = 1'b0;
        test_reset();
        test_identity();
        test_back_pressure();
        test_early_finish();
        test_missing_finish();
        test_sat();
        test_reset_mid_drain();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_left: %0d entries required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
